// File: rtl/ariscv_exe_if.sv
// Decode-to-execute operand/control bundle plus the execute outputs
// (fetch redirect and memory-stage pipeline register).
interface ariscv_exe_if #(
    parameter int NBW_PC       = 32,
    parameter int NBW_REGISTER = 32,
    parameter int NBW_ADDR     = 5
);
    logic                    i_valid;
    logic [NBW_REGISTER-1:0] i_rd1;
    logic [NBW_REGISTER-1:0] i_rd2;
    logic [NBW_REGISTER-1:0] i_immExt;
    logic [NBW_ADDR-1:0]     i_wr_addr_reg;
    logic [NBW_PC-1:0]       i_pc_de;
    logic [NBW_PC-1:0]       i_pc_plus4_de;
    logic                    i_regWrite;
    logic [1:0]              i_resultSrc;
    logic                    i_memWrite;
    logic                    i_jump;
    logic                    i_branch;
    logic [2:0]              i_aluControl;
    logic                    i_aluSrc;

    logic                    o_pc_src;
    logic [NBW_PC-1:0]       o_pc_target;
    logic [NBW_REGISTER-1:0] o_alu_result;
    logic [NBW_REGISTER-1:0] o_wr_data;
    logic [NBW_ADDR-1:0]     o_wr_addr_reg;
    logic [NBW_PC-1:0]       o_pc_plus4_ex;
    logic                    o_regWrite;
    logic [1:0]              o_resultSrc;
    logic                    o_memWrite;
    logic                    o_valid;

    // Decode side: drives operands/control, observes execute results.
    modport master (
        output i_valid, i_rd1, i_rd2, i_immExt, i_wr_addr_reg, i_pc_de,
               i_pc_plus4_de, i_regWrite, i_resultSrc, i_memWrite, i_jump,
               i_branch, i_aluControl, i_aluSrc,
        input  o_pc_src, o_pc_target, o_alu_result, o_wr_data, o_wr_addr_reg,
               o_pc_plus4_ex, o_regWrite, o_resultSrc, o_memWrite, o_valid
    );

    // Execute stage side.
    modport slave (
        input  i_valid, i_rd1, i_rd2, i_immExt, i_wr_addr_reg, i_pc_de,
               i_pc_plus4_de, i_regWrite, i_resultSrc, i_memWrite, i_jump,
               i_branch, i_aluControl, i_aluSrc,
        output o_pc_src, o_pc_target, o_alu_result, o_wr_data, o_wr_addr_reg,
               o_pc_plus4_ex, o_regWrite, o_resultSrc, o_memWrite, o_valid
    );
endinterface

// File: rtl/ariscv_exe.sv
// RV32I execute stage: ALU, branch/jump resolution with same-cycle fetch
// redirect, one-slot squash of the wrong-path decode instruction, and the
// execute-to-memory pipeline register.
module ariscv_exe #(
    parameter int NBW_PC       = 32,
    parameter int NBW_REGISTER = 32,
    parameter int NBW_ADDR     = 5
) (
    input  logic         ex_aclk,
    input  logic         rst_sync,
    ariscv_exe_if.slave  bus
);
    logic [NBW_REGISTER-1:0] src_a;
    logic [NBW_REGISTER-1:0] src_b;
    logic [NBW_REGISTER-1:0] alu_result;
    logic                    alu_zero;
    logic                    eff_valid;
    logic                    pc_src;
    logic [NBW_PC-1:0]       pc_target;
    logic [NBW_ADDR-1:0]     wr_addr;
    logic                    kill_ff;

    // Operand select and ALU.
    always_comb begin
        src_a      = bus.i_rd1;
        src_b      = bus.i_aluSrc ? bus.i_immExt : bus.i_rd2;
        alu_result = '0;
        case (bus.i_aluControl)
            3'b000:  alu_result = src_a + src_b;
            3'b001:  alu_result = src_a - src_b;
            3'b010:  alu_result = src_a & src_b;
            3'b011:  alu_result = src_a | src_b;
            3'b101:  alu_result = {{(NBW_REGISTER-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
            default: alu_result = '0;
        endcase
        alu_zero = (alu_result == '0);
    end

    // Redirect decision; a squashed slot can never redirect, so kills never chain.
    always_comb begin
        eff_valid = bus.i_valid & ~kill_ff;
        pc_src    = eff_valid & (bus.i_jump | (bus.i_branch & alu_zero));
        pc_target = bus.i_pc_de + bus.i_immExt[NBW_PC-1:0];
        wr_addr   = bus.i_wr_addr_reg;
    end

    assign bus.o_pc_src    = pc_src;
    assign bus.o_pc_target = pc_target;

    // Squash flag and memory-stage pipeline register; reset overrides a pending kill.
    always_ff @(posedge ex_aclk) begin
        if (rst_sync) begin
            kill_ff           <= 1'b0;
            bus.o_alu_result  <= '0;
            bus.o_wr_data     <= '0;
            bus.o_wr_addr_reg <= '0;
            bus.o_pc_plus4_ex <= '0;
            bus.o_regWrite    <= 1'b0;
            bus.o_resultSrc   <= '0;
            bus.o_memWrite    <= 1'b0;
            bus.o_valid       <= 1'b0;
        end else begin
            kill_ff           <= pc_src;
            bus.o_alu_result  <= alu_result;
            bus.o_wr_data     <= bus.i_rd2;
            bus.o_wr_addr_reg <= wr_addr;
            bus.o_pc_plus4_ex <= bus.i_pc_plus4_de;
            bus.o_regWrite    <= bus.i_regWrite & eff_valid;
            bus.o_resultSrc   <= bus.i_resultSrc;
            bus.o_memWrite    <= bus.i_memWrite & eff_valid;
            bus.o_valid       <= eff_valid;
        end
    end
endmodule

// File: tb/tb_ariscv_exe.sv
// Directed bench for the execute stage: ALU ops, redirect, squash, reset.
module tb_ariscv_exe;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    ariscv_exe_if #(.NBW_PC(32), .NBW_REGISTER(32), .NBW_ADDR(5)) bus ();

    ariscv_exe #(.NBW_PC(32), .NBW_REGISTER(32), .NBW_ADDR(5)) dut (
        .ex_aclk  (clk),
        .rst_sync (rst),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    // Count one comparison and report it if the observed value is wrong.
    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one clock; sample 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.i_valid       = 1'b0;
        bus.i_rd1         = '0;
        bus.i_rd2         = '0;
        bus.i_immExt      = '0;
        bus.i_wr_addr_reg = '0;
        bus.i_pc_de       = '0;
        bus.i_pc_plus4_de = '0;
        bus.i_regWrite    = 1'b0;
        bus.i_resultSrc   = '0;
        bus.i_memWrite    = 1'b0;
        bus.i_jump        = 1'b0;
        bus.i_branch      = 1'b0;
        bus.i_aluControl  = 3'b000;
        bus.i_aluSrc      = 1'b0;
    endtask

    // Register-register ALU op writing rd.
    task automatic alu_rr(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                          input logic [4:0] rd);
        idle();
        bus.i_valid       = 1'b1;
        bus.i_rd1         = a;
        bus.i_rd2         = b;
        bus.i_aluControl  = op;
        bus.i_regWrite    = 1'b1;
        bus.i_wr_addr_reg = rd;
    endtask

    // beq at pc with offset imm.
    task automatic beq(input logic [31:0] a, input logic [31:0] b, input logic [31:0] pc,
                       input logic [31:0] imm);
        idle();
        bus.i_valid       = 1'b1;
        bus.i_rd1         = a;
        bus.i_rd2         = b;
        bus.i_branch      = 1'b1;
        bus.i_aluControl  = 3'b001;
        bus.i_pc_de       = pc;
        bus.i_pc_plus4_de = pc + 32'd4;
        bus.i_immExt      = imm;
    endtask

    // Store: address rd1+imm, data rd2.
    task automatic store(input logic [31:0] base, input logic [31:0] data, input logic [31:0] imm);
        idle();
        bus.i_valid      = 1'b1;
        bus.i_rd1        = base;
        bus.i_rd2        = data;
        bus.i_immExt     = imm;
        bus.i_aluSrc     = 1'b1;
        bus.i_memWrite   = 1'b1;
    endtask

    initial begin
        idle();
        rst = 1'b1;
        step();
        step();
        check_eq("rst_valid", 32'(bus.o_valid), 32'd0);
        check_eq("rst_alu", bus.o_alu_result, 32'd0);
        check_eq("rst_regwrite", 32'(bus.o_regWrite), 32'd0);
        check_eq("rst_pc4", bus.o_pc_plus4_ex, 32'd0);
        rst = 1'b0;

        // add with signed-overflow wrap
        alu_rr(32'h7FFF_FFFF, 32'd1, 3'b000, 5'd3);
        #1 check_eq("add_pcsrc", 32'(bus.o_pc_src), 32'd0);
        step();
        check_eq("add_res", bus.o_alu_result, 32'h8000_0000);
        check_eq("add_regwrite", 32'(bus.o_regWrite), 32'd1);
        check_eq("add_valid", 32'(bus.o_valid), 32'd1);
        check_eq("add_rd", 32'(bus.o_wr_addr_reg), 32'd3);

        // sub wrap, and, or, undefined op
        alu_rr(32'd0, 32'd1, 3'b001, 5'd4);
        step();
        check_eq("sub_res", bus.o_alu_result, 32'hFFFF_FFFF);
        alu_rr(32'hF0F0_1234, 32'h0FF0_FF00, 3'b010, 5'd5);
        step();
        check_eq("and_res", bus.o_alu_result, 32'h00F0_1200);
        alu_rr(32'hF0F0_1234, 32'h0FF0_FF00, 3'b011, 5'd6);
        step();
        check_eq("or_res", bus.o_alu_result, 32'hFFF0_FF34);
        alu_rr(32'hF0F0_1234, 32'h0FF0_FF00, 3'b110, 5'd7);
        step();
        check_eq("op110_res", bus.o_alu_result, 32'd0);

        // slt signed, immediate operand
        idle();
        bus.i_valid = 1'b1; bus.i_rd1 = 32'hFFFF_FFFF; bus.i_immExt = 32'd5;
        bus.i_aluSrc = 1'b1; bus.i_aluControl = 3'b101; bus.i_rd2 = 32'hDEAD_BEEF;
        step();
        check_eq("slt_lt", bus.o_alu_result, 32'd1);
        check_eq("slt_wrdata", bus.o_wr_data, 32'hDEAD_BEEF);
        bus.i_rd1 = 32'd5; bus.i_immExt = 32'hFFFF_FFFF;
        step();
        check_eq("slt_ge", bus.o_alu_result, 32'd0);

        // beq taken, then squashed store, then normal add
        beq(32'h10, 32'h10, 32'h100, 32'hFFFF_FFF0);
        #1 check_eq("beq_pcsrc", 32'(bus.o_pc_src), 32'd1);
        check_eq("beq_target", bus.o_pc_target, 32'h0000_00F0);
        step();
        check_eq("beq_valid", 32'(bus.o_valid), 32'd1);
        store(32'h200, 32'h55, 32'd4);
        step();
        check_eq("kill_valid", 32'(bus.o_valid), 32'd0);
        check_eq("kill_memwrite", 32'(bus.o_memWrite), 32'd0);
        alu_rr(32'd2, 32'd3, 3'b000, 5'd8);
        step();
        check_eq("post_kill_valid", 32'(bus.o_valid), 32'd1);
        check_eq("post_kill_regwrite", 32'(bus.o_regWrite), 32'd1);
        check_eq("post_kill_res", bus.o_alu_result, 32'd5);

        // a killed jump must not redirect
        beq(32'h7, 32'h7, 32'h300, 32'h20);
        step();
        idle();
        bus.i_valid = 1'b1; bus.i_jump = 1'b1; bus.i_regWrite = 1'b1;
        #1 check_eq("killed_jump_pcsrc", 32'(bus.o_pc_src), 32'd0);
        step();
        check_eq("killed_jump_regwrite", 32'(bus.o_regWrite), 32'd0);

        // beq not taken: no redirect, next store not squashed
        beq(32'd1, 32'd2, 32'h400, 32'h40);
        #1 check_eq("bne_pcsrc", 32'(bus.o_pc_src), 32'd0);
        step();
        store(32'h200, 32'h66, 32'd8);
        step();
        check_eq("bne_store_valid", 32'(bus.o_valid), 32'd1);
        check_eq("bne_store_memwrite", 32'(bus.o_memWrite), 32'd1);
        check_eq("bne_store_addr", bus.o_alu_result, 32'h208);

        // jal with PC wrap; bubble next cycle still consumes the kill
        idle();
        bus.i_valid = 1'b1; bus.i_jump = 1'b1; bus.i_regWrite = 1'b1;
        bus.i_pc_de = 32'hFFFF_FFFC; bus.i_pc_plus4_de = 32'h0000_0000;
        bus.i_immExt = 32'd8; bus.i_resultSrc = 2'b10; bus.i_wr_addr_reg = 5'd1;
        bus.i_rd1 = 32'd9; bus.i_aluControl = 3'b000;
        #1 check_eq("jal_pcsrc", 32'(bus.o_pc_src), 32'd1);
        check_eq("jal_target", bus.o_pc_target, 32'h0000_0004);
        step();
        check_eq("jal_pc4", bus.o_pc_plus4_ex, 32'h0000_0000);
        check_eq("jal_regwrite", 32'(bus.o_regWrite), 32'd1);
        check_eq("jal_resultsrc", 32'(bus.o_resultSrc), 32'd2);
        idle();
        step();
        check_eq("bubble_valid", 32'(bus.o_valid), 32'd0);
        alu_rr(32'd10, 32'd4, 3'b001, 5'd9);
        step();
        check_eq("after_bubble_valid", 32'(bus.o_valid), 32'd1);
        check_eq("after_bubble_res", bus.o_alu_result, 32'd6);

        // reset while a kill is pending clears it
        beq(32'h0, 32'h0, 32'h500, 32'h10);
        step();
        alu_rr(32'd1, 32'd1, 3'b000, 5'd10);
        bus.i_pc_plus4_de = 32'h1234;
        rst = 1'b1;
        step();
        check_eq("midrst_valid", 32'(bus.o_valid), 32'd0);
        check_eq("midrst_alu", bus.o_alu_result, 32'd0);
        check_eq("midrst_rd", 32'(bus.o_wr_addr_reg), 32'd0);
        check_eq("midrst_pc4", bus.o_pc_plus4_ex, 32'd0);
        rst = 1'b0;
        idle();
        bus.i_valid = 1'b1; bus.i_jump = 1'b1; bus.i_regWrite = 1'b1;
        bus.i_pc_de = 32'h600; bus.i_immExt = 32'h8;
        #1 check_eq("postrst_pcsrc", 32'(bus.o_pc_src), 32'd1);
        step();
        check_eq("postrst_valid", 32'(bus.o_valid), 32'd1);
        check_eq("postrst_regwrite", 32'(bus.o_regWrite), 32'd1);

        idle();
        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/ariscv_exe.md
Name: ariscv_exe

Overview:
- Execute stage of the pipelined RV32I core; sits directly downstream of the decode stage and consumes its registered operands, immediate, PC values and control bundle.
- Performs the ALU operation, resolves branch/jump and drives the PC redirect back to fetch.
- Squashes the wrong-path instruction already latched in the decode register.
- Registers results and control for the memory stage.

Parameters:
- NBW_PC, 32, PC width
- NBW_REGISTER, 32, datapath/register width
- NBW_ADDR, 5, register-file address width

Ports:
- ex_aclk  in  1  stage clock
- rst_sync  in  1  reset, synchronous to ex_aclk, active-high
- i_valid  in  1  decode output holds a real instruction
- i_rd1  in  NBW_REGISTER  source operand 1
- i_rd2  in  NBW_REGISTER  source operand 2 / store data
- i_immExt  in  NBW_REGISTER  sign-extended immediate
- i_wr_addr_reg  in  NBW_ADDR  destination register
- i_pc_de  in  NBW_PC  instruction PC
- i_pc_plus4_de  in  NBW_PC  PC+4
- i_regWrite  in  1  control from decode
- i_resultSrc  in  2  control from decode
- i_memWrite  in  1  control from decode
- i_jump  in  1  control from decode
- i_branch  in  1  control from decode
- i_aluControl  in  3  control from decode
- i_aluSrc  in  1  control from decode
- o_pc_src  out  1  combinational: redirect fetch to o_pc_target
- o_pc_target  out  NBW_PC  combinational: i_pc_de + i_immExt, modulo 2^NBW_PC
- o_alu_result  out  NBW_REGISTER  registered ALU result
- o_wr_data  out  NBW_REGISTER  registered i_rd2 (store data)
- o_wr_addr_reg  out  NBW_ADDR  registered destination
- o_pc_plus4_ex  out  NBW_PC  registered PC+4
- o_regWrite  out  1  registered, qualified by valid
- o_resultSrc  out  2  registered
- o_memWrite  out  1  registered, qualified by valid
- o_valid  out  1  registered valid to memory stage

Behaviour:
- Single clock ex_aclk; reset rst_sync is synchronous and active-high. All flops update on posedge ex_aclk only.
- Reset: all registered outputs = 0; internal kill_ff = 0. Reset has priority over every other event, including a pending kill.
- Operand selection:
  - srcA = i_rd1.
  - srcB = i_aluSrc ? i_immExt : i_rd2.
- ALU, by i_aluControl:
  - 000 add; 001 sub. Both wrap modulo 2^NBW_REGISTER with no overflow flag.
  - 010 and; 011 or.
  - 101 slt: signed compare, result 1 or 0 zero-extended.
  - 100, 110, 111: result 0.
- zero = (alu result == 0).
- Effective valid: eff_valid = i_valid & ~kill_ff.
- Redirect: o_pc_src = eff_valid & (i_jump | (i_branch & zero)).
  - Combinational, same cycle the instruction is in execute.
  - o_pc_target is always driven; it is only meaningful when o_pc_src = 1.
- kill_ff: next value = o_pc_src.
  - Effect: the one instruction presented in the cycle after a taken redirect is squashed. That is the wrong-path instruction held in the decode register.
  - Fetch is redirected in the same cycle, so only one slot is killed.
- Back-to-back: a killed instruction cannot raise o_pc_src, so kill_ff clears after exactly one cycle. There is no chain of squashes.
- i_valid = 0 while kill_ff = 1: the kill is still consumed (kill_ff clears); it is not held over.
- Pipeline register, every non-reset cycle:
  - o_valid <= eff_valid.
  - o_regWrite <= i_regWrite & eff_valid.
  - o_memWrite <= i_memWrite & eff_valid.
  - Data fields (alu result, i_rd2, i_wr_addr_reg, i_pc_plus4_de, i_resultSrc) are captured unconditionally; downstream qualifies them with o_valid.
- Latency: 1 cycle from decode outputs to memory-stage outputs; 0 cycles for o_pc_src / o_pc_target.
- JAL: i_jump = 1 with ALU result ignored downstream (i_resultSrc selects PC+4); the redirect is independent of zero.

Test Plan:
- Reset mid-stream: rst_sync = 1 for one cycle while kill_ff = 1 -> all outputs 0, kill_ff = 0; next valid instruction passes unsquashed.
- R-type add: i_rd1 = 0x7FFFFFFF, i_rd2 = 1, aluSrc = 0, aluControl = 000, regWrite = 1 -> next cycle o_alu_result = 0x80000000, o_regWrite = 1, o_valid = 1; o_pc_src = 0.
- slt signed: i_rd1 = 0xFFFFFFFF, immExt = 5, aluSrc = 1, aluControl = 101 -> o_alu_result = 1. Swap operands -> 0.
- beq taken: i_rd1 = i_rd2 = 0x10, branch = 1, aluControl = 001, pc_de = 0x100, immExt = 0xFFFFFFF0 -> same cycle o_pc_src = 1, o_pc_target = 0x0F0.
  - Following instruction (a store with memWrite = 1) -> o_valid = 0, o_memWrite = 0.
  - Third instruction passes normally.
- beq not taken: i_rd1 = 1, i_rd2 = 2 -> o_pc_src = 0, no squash.
- jal at pc 0xFFFFFFFC, immExt = 8 -> o_pc_target = 0x00000004 (wrap). Next cycle o_pc_plus4_ex = 0x00000000, o_regWrite = 1. The next-cycle input with i_valid = 0 still clears kill_ff.
